// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with single-cycle ops, N-cycle shift-add multiply and a one-entry output register
module alu_pipe #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_alu_control,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_result,
  output logic         o_zero,
  output logic         o_overflow,
  output logic         o_sticky_ovf,
  input  logic         i_clr_sticky
);
  localparam int CW = $clog2(N);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
                         OP_OR = 3'd4, OP_SLT = 3'd5, OP_SLTU = 3'd6, OP_MUL = 3'd7;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_mcand;
  logic [2*N-1:0]  r_prod;
  logic            r_out_valid;
  logic [N-1:0]    r_result;
  logic            r_zero;
  logic            r_overflow;
  logic            r_sticky;

  logic            w_accept;
  logic [N-1:0]    w_sum;
  logic [N-1:0]    w_diff;
  logic [N-1:0]    w_alu_result;
  logic            w_alu_ovf;
  logic [N:0]      w_mul_add;
  logic [2*N-1:0]  w_prod_next;
  logic            w_mul_last;
  logic            w_done;
  logic [N-1:0]    w_done_result;
  logic            w_done_ovf;

  assign o_in_ready = (r_state == IDLE) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_sum      = i_a + i_b;
  assign w_diff     = i_a - i_b;

  always_comb begin
    w_alu_result = '0;
    w_alu_ovf    = 1'b0;
    case (i_alu_control)
      OP_ADD: begin
        w_alu_result = w_sum;
        w_alu_ovf    = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      OP_SUB: begin
        w_alu_result = w_diff;
        w_alu_ovf    = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
      end
      OP_AND:  w_alu_result = i_a & i_b;
      OP_XOR:  w_alu_result = i_a ^ i_b;
      OP_OR:   w_alu_result = i_a | i_b;
      OP_SLT:  w_alu_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_alu_result = {{(N-1){1'b0}}, (i_a < i_b)};
      default: w_alu_result = '0;
    endcase
  end

  // Product register holds {partial sum, remaining multiplier bits}; shift right one bit per step.
  assign w_mul_add   = {1'b0, r_prod[2*N-1:N]} + {1'b0, (r_prod[0] ? r_mcand : {N{1'b0}})};
  assign w_prod_next = {w_mul_add, r_prod[N-1:1]};
  assign w_mul_last  = (r_state == MUL_BUSY) && (r_cnt == CW'(N-1));

  assign w_done        = (w_accept && (i_alu_control != OP_MUL)) || w_mul_last;
  assign w_done_result = w_mul_last ? w_prod_next[N-1:0] : w_alu_result;
  assign w_done_ovf    = w_mul_last ? (|w_prod_next[2*N-1:N]) : w_alu_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_overflow  <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && (i_alu_control == OP_MUL)) begin
            r_mcand <= i_a;
            r_prod  <= {{N{1'b0}}, i_b};
            r_cnt   <= '0;
            r_state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_mul_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_done_result;
        r_zero      <= (w_done_result == '0);
        r_overflow  <= w_done_ovf;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A new overflow completion outranks a clear on the same edge.
      if (w_done && w_done_ovf) r_sticky <= 1'b1;
      else if (i_clr_sticky)    r_sticky <= 1'b0;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_result     = r_result;
  assign o_zero       = r_zero;
  assign o_overflow   = r_overflow;
  assign o_sticky_ovf = r_sticky;

endmodule
